// File: rtl/adder_accum.sv
// adder_accum: sums NUM adder results {cout,s} per burst, then holds the total.
// Optional: define ADDER_ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   clr             synchronous burst abort
//   in_valid/ready  sample handshake; in_s + in_cout form the sample
//   out_valid/ready result handshake
//   out_acc/out_ovf live accumulator and sticky overflow flag
//   busy            state is not IDLE

module adder_accum #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10,
  parameter int NUM    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_s,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [7:0] NUM_C = 8'(NUM);

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  logic [ACC_W:0]   w_val;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [7:0]       w_cnt_nxt;

  // Zero-extended sample, one spare bit to catch the carry out of ACC_W.
  assign w_val     = {{(ACC_W-DATA_W){1'b0}}, in_cout, in_s};
  assign w_sum     = {1'b0, r_acc} + w_val;
  assign w_cnt_nxt = r_cnt + 8'd1;

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
`ifdef ADDER_ACCUM_SATURATE_EN
    // Once clamped, any further nonzero add overflows again,
    // so the all-ones value sticks for the rest of the burst.
    if (w_sum[ACC_W]) begin
      w_acc_nxt = '1;
    end
`endif
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (in_valid) begin
            r_acc   <= w_val[ACC_W-1:0];
            r_cnt   <= 8'd1;
            r_ovf   <= 1'b0;
            r_state <= S_ACCUM;
          end
        end
        (r_state == S_ACCUM): begin
          if (in_valid) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_sum[ACC_W];
            if (w_cnt_nxt == NUM_C) begin
              r_state <= S_HOLD;
            end
          end
        end
        (r_state == S_HOLD): begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: directed vectors for adder_accum,
// default build and ACC_W=6 instance side by side.

module tb_adder_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [3:0] in_s;
  logic       in_cout;
  logic       out_ready;

  logic       in_ready, out_valid, out_ovf, busy;
  logic [9:0] out_acc;

  logic       in_ready6, out_valid6, out_ovf6, busy6;
  logic [5:0] out_acc6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_accum u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  adder_accum #(.DATA_W(4), .ACC_W(6), .NUM(4)) u_dut6 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready6),
    .in_s(in_s), .in_cout(in_cout),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_acc(out_acc6), .out_ovf(out_ovf6), .busy(busy6)
  );

  typedef struct {
    logic [3:0][4:0] smp;
    int acc;
    int ovf;
    int acc6w;
    int acc6s;
    int ovf6;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0][4:0] mk(input int a, input int b,
                                         input int c, input int d);
    logic [3:0][4:0] r;
    r[0] = 5'(a);
    r[1] = 5'(b);
    r[2] = 5'(c);
    r[3] = 5'(d);
    return r;
  endfunction

  task automatic send(input logic [4:0] v);
    {in_cout, in_s} = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  int exp6;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_s = '0; in_cout = 1'b0; out_ready = 1'b0;

    vecs[0] = '{mk(0, 0, 0, 0),      0, 0,  0,  0, 0};
    vecs[1] = '{mk(2, 12, 6, 16),   36, 0, 36, 36, 0};
    vecs[2] = '{mk(31, 31, 31, 31), 124, 0, 60, 63, 1};
    vecs[3] = '{mk(31, 31, 1, 0),   63, 0, 63, 63, 0};
    vecs[4] = '{mk(31, 31, 2, 5),   69, 0,  5, 63, 1};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("v%0d_in_ready%0d", i, j), int'(in_ready), 1);
        send(vecs[i].smp[j]);
        if (j == 2) chk($sformatf("v%0d_early_valid", i), int'(out_valid), 0);
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
      chk($sformatf("v%0d_out_acc", i), int'(out_acc), vecs[i].acc);
      chk($sformatf("v%0d_out_ovf", i), int'(out_ovf), vecs[i].ovf);
`ifdef ADDER_ACCUM_SATURATE_EN
      exp6 = vecs[i].acc6s;
`else
      exp6 = vecs[i].acc6w;
`endif
      chk($sformatf("v%0d_acc6", i), int'(out_acc6), exp6);
      chk($sformatf("v%0d_ovf6", i), int'(out_ovf6), vecs[i].ovf6);
      drain();
      chk($sformatf("v%0d_drained", i), int'(out_valid), 0);
    end

    // Backpressure with in_valid held high
    for (int j = 0; j < 4; j++) send(5'd1);
    in_s = 4'd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_acc", int'(out_acc), 4);
    end
    drain();
    chk("bp_out_valid_after", int'(out_valid), 0);
    chk("bp_in_ready_after", int'(in_ready), 1);
    chk("bp_no_accept", int'(busy), 0);
    in_valid = 1'b0;

    // clr overrides a concurrent input transfer mid-burst
    send(5'd5);
    send(5'd5);
    {in_cout, in_s} = 5'd5;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_acc", int'(out_acc), 0);
    for (int j = 0; j < 4; j++) send(5'd1);
    in_valid = 1'b0;
    chk("clr_burst_valid", int'(out_valid), 1);
    chk("clr_burst_acc", int'(out_acc), 4);

    // clr in HOLD overrides the output transfer
    out_ready = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    out_ready = 1'b0;
    chk("clr_hold_valid", int'(out_valid), 0);
    chk("clr_hold_acc", int'(out_acc), 0);

    // Async reset while holding a result with overflow
    for (int j = 0; j < 4; j++) send(5'd31);
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid6), 1);
    chk("pre_rst_ovf6", int'(out_ovf6), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_out_acc", int'(out_acc), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_ovf6", int'(out_ovf6), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) send(5'd3);
    in_valid = 1'b0;
    chk("post_rst_acc", int'(out_acc), 12);
    chk("post_rst_valid", int'(out_valid), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_accum.md
ADDER_ACCUM -- requirements
Module: adder_accum

Interface
- REQ-001 The block SHALL take parameter DATA_W, default 4: width of the upstream adder sum `in_s`.
- REQ-002 The block SHALL take parameter ACC_W, default 10: accumulator width, legal range DATA_W+1 .. 32.
- REQ-003 The block SHALL take parameter NUM, default 4: accepted samples per burst, legal range 2 .. 255.
- REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 Port clr, input, 1 bit: synchronous burst abort.
- REQ-007 Port in_valid, input, 1 bit: upstream sample valid.
- REQ-008 Port in_ready, output, 1 bit: block can accept a sample.
- REQ-009 Port in_s, input, DATA_W bits: adder sum.
- REQ-010 Port in_cout, input, 1 bit: adder carry-out.
- REQ-011 Port out_valid, output, 1 bit: burst result available.
- REQ-012 Port out_ready, input, 1 bit: downstream accepts the result.
- REQ-013 Port out_acc, output, ACC_W bits: accumulator value.
- REQ-014 Port out_ovf, output, 1 bit: overflow occurred in the current burst.
- REQ-015 Port busy, output, 1 bit: state is not IDLE.

Function
- REQ-016 Sample value SHALL be {in_cout,in_s}, zero-extended to ACC_W bits.
- REQ-017 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
- REQ-018 Output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
- REQ-019 FSM states SHALL be IDLE, ACCUM and HOLD.
- REQ-020 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; it is a registered state decode with no combinational path from out_ready.
- REQ-021 On a transfer in IDLE: acc=value, cnt=1, ovf=0, next state ACCUM.
- REQ-022 On a transfer in ACCUM: acc=acc+value, cnt=cnt+1, computed at ACC_W+1 bits.
- REQ-023 When cnt reaches NUM on a transfer, next state SHALL be HOLD.
- REQ-024 Latency: out_valid SHALL rise on the cycle after the NUM-th transfer.
- REQ-025 In HOLD, out_valid=1, and out_acc and out_ovf SHALL be stable until the output transfer.
- REQ-026 On an output transfer the next state SHALL be IDLE and out_valid SHALL be 0 the next cycle; an input is not accepted in that same cycle.
- REQ-027 Overflow (bit ACC_W of the sum set) SHALL set ovf, which is sticky until the next burst start.
- REQ-028 out_acc SHALL reflect the live accumulator in every state; it is meaningful only while out_valid=1.
- REQ-029 A clr sampled high SHALL force IDLE with acc=0, cnt=0, ovf=0 next cycle, discarding any partial burst or HOLD result; clr overrides a simultaneous input or output transfer.
- REQ-030 The block SHALL ignore in_valid while in HOLD, and SHALL ignore out_ready outside HOLD.

Reset
- REQ-031 rst=1 SHALL asynchronously force state IDLE, acc=0, cnt=0, ovf=0.
- REQ-032 While rst=1, outputs SHALL be out_valid=0, in_ready=1, busy=0, out_acc=0, out_ovf=0.
- REQ-033 A reset in any state, including mid-burst or HOLD, SHALL discard the burst; operation resumes on the first edge after rst deasserts.

Configuration
- REQ-034 The block SHALL use macro ADDER_ACCUM_SATURATE_EN to select saturating versus wrapping accumulation.
- REQ-035 With ADDER_ACCUM_SATURATE_EN defined, an overflowing add SHALL clamp acc to all-ones, and acc SHALL then remain all-ones for the rest of the burst; ovf SHALL be set.
- REQ-036 With ADDER_ACCUM_SATURATE_EN undefined, acc SHALL wrap modulo 2^ACC_W; ovf SHALL be set.

Verification
- REQ-037 Defaults, four samples {0,0000} -> out_valid 1 cycle after the 4th transfer, out_acc=0, out_ovf=0.
- REQ-038 Defaults, samples {0,0010},{0,1100},{0,0110},{1,0000} (2+12+6+16) -> out_acc=36, out_ovf=0.
- REQ-039 ACC_W=6, four samples of 31 (sum 124) -> without the macro out_acc=60, out_ovf=1; with the macro out_acc=63, out_ovf=1.
- REQ-040 Backpressure: burst done, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_acc stable, then out_ready=1 gives IDLE and in_ready=1 next cycle.
- REQ-041 clr after 2 transfers, then 4 samples of 1 -> out_acc=4 (the first partial burst is discarded).
- REQ-042 rst pulse while in HOLD -> out_valid=0 immediately, without waiting for clk; busy=0 and out_acc=0.
